// File: rtl/axis_mii_rx_if.sv
// axis_mii_rx_if: receive-side AXI stream bundle (no ready; sink always accepts).
// master drives the beat, slave observes it.
interface axis_mii_rx_if;
    logic [7:0] axis_data;
    logic       axis_valid;
    logic       axis_last;
    logic       axis_err;

    modport master (output axis_data, axis_valid, axis_last, axis_err);
    modport slave  (input  axis_data, axis_valid, axis_last, axis_err);
endinterface

// File: rtl/axis_mii_rx.sv
// axis_mii_rx: MII nibble receiver to AXI stream with CRC-32 and length checks.
// Define AXIS_MII_RX_STRIP_FCS_EN to drop the 4 FCS bytes from the stream.
module axis_mii_rx #(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mii_rx_ce,
    input  logic          mii_rx_dv,
    input  logic [3:0]    mii_rxd,
    input  logic          mii_rx_er,
    axis_mii_rx_if.master axis,
    output logic          frame_ok,
    output logic          fcs_error,
    output logic          frame_error,
    output logic          too_short,
    output logic          too_long
);
`ifdef AXIS_MII_RX_STRIP_FCS_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 1;
`endif
    localparam logic [2:0]  HOLD_N   = 3'(HOLD);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] LONG_LEN = 11'(MAX_FRAME_BYTES + 1);
    localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
    state_t state_q, state_d;

    logic [31:0] crc_q;
    logic [10:0] cnt_q;
    logic        nib_q;
    logic [3:0]  lo_q;
    logic        er_q;
    logic [2:0]  hcnt_q;
    logic [7:0]  hold_q [HOLD];
    logic [7:0]  data_q;
    logic        valid_q, last_q, err_q;

    logic        sfd, byte_done, frame_end, too_long_hit;
    logic [7:0]  byte_in;
    logic [10:0] cnt_inc;
    logic [31:0] crc_nx;
    logic        fcs_bad, short_f, frm_err, any_err, emit;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign byte_in      = {mii_rxd, lo_q};
    assign cnt_inc      = (cnt_q == 11'h7ff) ? cnt_q : cnt_q + 11'd1;
    assign crc_nx       = crc_byte(crc_q, byte_in);
    assign too_long_hit = byte_done && (cnt_inc == LONG_LEN);
    assign fcs_bad      = crc_q != RESIDUE;
    assign short_f      = cnt_q < MIN_LEN;
    assign frm_err      = nib_q | er_q;
    assign any_err      = fcs_bad | short_f | frm_err;
    // the pipeline only releases once it is full of bytes
    assign emit         = hcnt_q == HOLD_N;

    assign axis.axis_data  = data_q;
    assign axis.axis_valid = valid_q;
    assign axis.axis_last  = last_q;
    assign axis.axis_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sfd       = 1'b0;
        byte_done = 1'b0;
        frame_end = 1'b0;
        if (mii_rx_ce) begin
            unique case (state_q)
                IDLE: begin
                    if (mii_rx_dv)
                        state_d = (mii_rxd == 4'h5) ? PREAMBLE : DROP;
                end
                PREAMBLE: begin
                    if (!mii_rx_dv) begin
                        state_d = IDLE;
                    end else if (mii_rxd == 4'hd) begin
                        state_d = DATA;
                        sfd     = 1'b1;
                    end else if (mii_rxd != 4'h5) begin
                        state_d = DROP;
                    end
                end
                DATA: begin
                    if (!mii_rx_dv) begin
                        state_d   = IDLE;
                        frame_end = 1'b1;
                    end else if (nib_q) begin
                        byte_done = 1'b1;
                        if (cnt_inc == LONG_LEN) state_d = DROP;
                    end
                end
                DROP: begin
                    if (!mii_rx_dv) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q       <= '1;
            cnt_q       <= '0;
            nib_q       <= 1'b0;
            lo_q        <= '0;
            er_q        <= 1'b0;
            hcnt_q      <= '0;
            for (int i = 0; i < HOLD; i++) hold_q[i] <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_ok    <= 1'b0;
            fcs_error   <= 1'b0;
            frame_error <= 1'b0;
            too_short   <= 1'b0;
            too_long    <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_ok    <= 1'b0;
            fcs_error   <= 1'b0;
            frame_error <= 1'b0;
            too_short   <= 1'b0;
            too_long    <= 1'b0;
            if (sfd) begin
                crc_q  <= '1;
                cnt_q  <= '0;
                nib_q  <= 1'b0;
                er_q   <= 1'b0;
                hcnt_q <= '0;
            end
            if (mii_rx_ce && state_q == DATA && mii_rx_dv) begin
                er_q  <= er_q | mii_rx_er;
                nib_q <= ~nib_q;
                if (!nib_q) lo_q <= mii_rxd;
            end
            if (byte_done) begin
                crc_q     <= crc_nx;
                cnt_q     <= cnt_inc;
                hold_q[0] <= byte_in;
                for (int i = HOLD - 1; i > 0; i--) hold_q[i] <= hold_q[i-1];
                if (emit) begin
                    data_q  <= hold_q[HOLD-1];
                    valid_q <= 1'b1;
                end else begin
                    hcnt_q <= hcnt_q + 3'd1;
                end
                if (too_long_hit) begin
                    last_q   <= emit;
                    err_q    <= emit;
                    too_long <= 1'b1;
                end
            end
            // an empty frame reports only its shortness
            if (frame_end) begin
                if (cnt_q == '0) begin
                    too_short <= 1'b1;
                end else begin
                    if (emit) begin
                        data_q  <= hold_q[HOLD-1];
                        valid_q <= 1'b1;
                        last_q  <= 1'b1;
                        err_q   <= any_err;
                    end
                    frame_ok    <= ~any_err;
                    fcs_error   <= fcs_bad;
                    frame_error <= frm_err;
                    too_short   <= short_f;
                end
            end
        end
    end
endmodule

// File: doc/axis_mii_rx.md
AXIS_MII_RX -- requirements
Module: axis_mii_rx

Interface
REQ-001 SHALL have parameter MIN_FRAME_BYTES, default 64: minimum legal frame length, including FCS.
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 1518: maximum legal frame length, including FCS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mii_rx_ce, input, 1 bit: MII sample enable; one pulse per nibble time.
REQ-006 SHALL have ports mii_rx_dv (input, 1), mii_rxd (input, 4) and mii_rx_er (input, 1): MII receive data valid, receive nibble and receive error.
REQ-007 SHALL have ports axis_data (output, 8), axis_valid (output, 1), axis_last (output, 1) and axis_err (output, 1): AXI stream master with no ready; the consumer always accepts.
REQ-008 SHALL have ports frame_ok, fcs_error, frame_error, too_short and too_long, each output, 1 bit: one-cycle status pulses.

Function
REQ-009 SHALL sample MII inputs only in cycles where mii_rx_ce=1; all other cycles hold state.
REQ-010 SHALL implement the states IDLE, PREAMBLE, DATA and DROP.
REQ-011 IDLE: dv=1 with rxd=5 -> PREAMBLE; dv=1 with any other nibble -> DROP.
REQ-012 PREAMBLE: nibble 5 stays; nibble D (SFD) -> DATA; any other nibble -> DROP; dv=0 -> IDLE; no AXI output.
REQ-013 DATA: nibbles SHALL assemble low nibble first into bytes, and the byte counter SHALL saturate at 2047 (11 bits).
REQ-014 CRC SHALL be a reflected Galois CRC-32, polynomial 04C11DB7, init FFFFFFFF, computed over every byte after the SFD, FCS included.
REQ-015 FCS SHALL be good iff the final CRC state equals DEBB20E3.
REQ-016 Output SHALL lag by one byte: a completed byte is held and released (axis_valid=1 for exactly one clk) one clk after the ce sample that completes the next byte.
REQ-017 On dv=0 in DATA, the held byte SHALL be emitted one clk later with axis_last=1; state -> IDLE.
REQ-018 axis_err SHALL be valid only with axis_last, and SHALL be 1 if any of these holds: bad FCS, odd nibble count, mii_rx_er seen during DATA, or length < MIN_FRAME_BYTES.
REQ-019 Status pulses SHALL coincide with the last beat: frame_ok iff no error; fcs_error for bad FCS; frame_error for odd nibble or rx_er; too_short for length < MIN_FRAME_BYTES.
REQ-020 When the length reaches MAX_FRAME_BYTES+1, the held byte SHALL be emitted with last=1, err=1, too_long=1; state -> DROP.
REQ-021 DROP: no output; dv=0 -> IDLE.
REQ-022 mii_rx_er SHALL NOT abort collection; it only sets the error flag.
REQ-023 SFD followed immediately by dv=0 (zero bytes) SHALL produce no AXI beat, and SHALL pulse only too_short.
REQ-024 dv rising and falling in the same ce sample is impossible; dv=0 in any state -> IDLE, except that IDLE stays IDLE.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state IDLE; all outputs 0; CRC FFFFFFFF; counter 0; held-byte valid 0; error flags 0.
REQ-026 After reset release mid-frame, the block SHALL start in IDLE; if dv is already 1 with a non-5 nibble -> DROP until dv=0; no partial frame is emitted.

Configuration
REQ-027 Macro AXIS_MII_RX_STRIP_FCS_EN SHALL select FCS stripping.
REQ-028 Macro undefined: FCS bytes SHALL be forwarded; hold depth is 1 byte (REQ-016).
REQ-029 Macro defined: hold depth SHALL be 5 bytes; byte i is released when byte i+5 completes; at frame end the oldest held byte is emitted with last and the 4 FCS bytes are discarded.
REQ-030 Macro defined: frames shorter than 5 bytes SHALL produce no AXI beat (status pulses only). Length checks, CRC and status are identical in both builds.

Verification
REQ-031 7x55, D5, 60 data bytes plus correct FCS -> 64 beats (60 with STRIP), last on final beat, err=0, frame_ok=1.
REQ-032 Same frame with one FCS bit flipped -> last with err=1, fcs_error=1, frame_ok=0.
REQ-033 Good 64-byte frame plus one extra nibble, or rx_er pulsed on byte 10 -> err=1, frame_error=1, beat count otherwise unchanged.
REQ-034 Good 40-byte frame -> err=1, too_short=1; 1600-byte stream -> last at byte 1518 with err=1, too_long=1, nothing further until dv low.
REQ-035 Preamble 55 55 A5 -> no beats, DROP; then a good frame -> received normally.
REQ-036 rst_n pulled low at byte 30 of a frame, released at byte 31 -> no output for that frame; the next frame is received with frame_ok=1.
